// File: rtl/sprite_boxes_seq.sv
// Per-fighter collision box generator, registered once per video frame.
// Hurtbox always live; hitbox live only for a short window after entering an
// active attack state, and killed early once the collision checker reports a hit.
module sprite_boxes_seq #(
  parameter int CW         = 10,
  parameter int SPRITE_W   = 64,
  parameter int SPRITE_H   = 128,
  parameter int HURT_M     = 10,
  parameter int REC_M      = 5,
  parameter int HB_W_BASIC = 30,
  parameter int HB_H_BASIC = 60,
  parameter int HB_W_DIR   = 40,
  parameter int HB_H_DIR   = 48,
  parameter int ACT_FRAMES = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_tick,
  input  logic [3:0]    i_state,
  input  logic          i_facing_left,
  input  logic [CW-1:0] i_sprite_x,
  input  logic [CW-1:0] i_sprite_y,
  input  logic          i_hit_ack,
  output logic [CW-1:0] o_hitbox_x1,
  output logic [CW-1:0] o_hitbox_x2,
  output logic [CW-1:0] o_hitbox_y1,
  output logic [CW-1:0] o_hitbox_y2,
  output logic [CW-1:0] o_hurtbox_x1,
  output logic [CW-1:0] o_hurtbox_x2,
  output logic [CW-1:0] o_hurtbox_y1,
  output logic [CW-1:0] o_hurtbox_y2,
  output logic          o_hitbox_active,
  output logic          o_hurtbox_active,
  output logic [7:0]    o_act_cnt
);

  // One spare bit so sums can exceed the screen and be clamped instead of wrapping.
  typedef logic [CW:0]   ext_t;
  typedef logic [CW-1:0] crd_t;

  localparam ext_t       XMAX    = ext_t'((1 << CW) - 1);
  localparam logic [3:0] ST_ATK  = 4'd4;
  localparam logic [3:0] ST_ATKR = 4'd5;
  localparam logic [3:0] ST_DIR  = 4'd7;
  localparam logic [3:0] ST_DIRR = 4'd8;
  localparam logic [7:0] ACT_LIM = 8'(ACT_FRAMES);

  function automatic crd_t sat(input ext_t v);
    return (v > XMAX) ? XMAX[CW-1:0] : v[CW-1:0];
  endfunction

  logic [3:0] r_prev_state;
  logic [7:0] r_act_cnt;
  logic       r_consumed;
  crd_t       r_hit_x1, r_hit_x2, r_hit_y1, r_hit_y2;
  crd_t       r_hurt_x1, r_hurt_x2, r_hurt_y1, r_hurt_y2;
  logic       r_hit_active, r_hurt_active;

  logic       w_is_act, w_same, w_clear, w_set, w_consumed_next, w_hit_active;
  logic [7:0] w_cnt_next;
  ext_t       w_sx, w_sy, w_m, w_hb_w, w_hb_h, w_hb_yoff, w_ldiff;
  crd_t       w_hurt_x1, w_hurt_x2, w_hurt_y2;
  crd_t       w_hit_x1, w_hit_x2, w_hit_y1, w_hit_y2;
  crd_t       w_rx1;

  // Next-frame window counter, consume latch and box geometry.
  always_comb begin
    w_is_act = (i_state == ST_ATK) || (i_state == ST_DIR);
    w_same   = (i_state == r_prev_state);

    w_cnt_next = 8'd0;
    if (w_is_act && w_same)
      w_cnt_next = (r_act_cnt == 8'hFF) ? 8'hFF : r_act_cnt + 8'd1;

    // Clear only happens on a tick and overrides a simultaneous set.
    w_clear         = i_frame_tick && (!w_is_act || !w_same);
    w_set           = i_hit_ack && r_hit_active;
    w_consumed_next = w_clear ? 1'b0 : (r_consumed || w_set);
    w_hit_active    = w_is_act && (w_cnt_next < ACT_LIM) && !w_consumed_next;

    w_sx = ext_t'(i_sprite_x);
    w_sy = ext_t'(i_sprite_y);

    w_m = ((i_state == ST_ATKR) || (i_state == ST_DIRR)) ? ext_t'(REC_M) : ext_t'(HURT_M);
    w_hurt_x1 = sat(w_sx + w_m);
    w_hurt_x2 = sat(w_sx + ext_t'(SPRITE_W) - w_m);
    w_hurt_y2 = sat(w_sy + ext_t'(SPRITE_H));

    if (i_state == ST_DIR) begin
      w_hb_w    = ext_t'(HB_W_DIR);
      w_hb_h    = ext_t'(HB_H_DIR);
      w_hb_yoff = ext_t'((SPRITE_H - HB_H_DIR) / 2);
    end else begin
      w_hb_w    = ext_t'(HB_W_BASIC);
      w_hb_h    = ext_t'(HB_H_BASIC);
      w_hb_yoff = ext_t'((SPRITE_H - HB_H_BASIC) / 2);
    end

    w_rx1   = sat(w_sx + ext_t'(SPRITE_W));
    w_ldiff = w_sx - w_hb_w;

    w_hit_x1 = '0;
    w_hit_x2 = '0;
    w_hit_y1 = '0;
    w_hit_y2 = '0;
    if (w_hit_active) begin
      w_hit_y1 = sat(w_sy + w_hb_yoff);
      w_hit_y2 = sat(ext_t'(w_hit_y1) + w_hb_h);
      if (i_facing_left) begin
        w_hit_x2 = i_sprite_x;
        w_hit_x1 = (w_sx >= w_hb_w) ? w_ldiff[CW-1:0] : '0;
      end else begin
        w_hit_x1 = w_rx1;
        w_hit_x2 = sat(ext_t'(w_rx1) + w_hb_w);
      end
    end
  end

  // Consume latch tracks every cycle; everything else loads only on the frame tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_state  <= '0;
      r_act_cnt     <= '0;
      r_consumed    <= 1'b0;
      r_hit_x1      <= '0;
      r_hit_x2      <= '0;
      r_hit_y1      <= '0;
      r_hit_y2      <= '0;
      r_hurt_x1     <= '0;
      r_hurt_x2     <= '0;
      r_hurt_y1     <= '0;
      r_hurt_y2     <= '0;
      r_hit_active  <= 1'b0;
      r_hurt_active <= 1'b0;
    end else begin
      r_consumed <= w_consumed_next;
      if (i_frame_tick) begin
        r_prev_state  <= i_state;
        r_act_cnt     <= w_cnt_next;
        r_hit_x1      <= w_hit_x1;
        r_hit_x2      <= w_hit_x2;
        r_hit_y1      <= w_hit_y1;
        r_hit_y2      <= w_hit_y2;
        r_hurt_x1     <= w_hurt_x1;
        r_hurt_x2     <= w_hurt_x2;
        r_hurt_y1     <= i_sprite_y;
        r_hurt_y2     <= w_hurt_y2;
        r_hit_active  <= w_hit_active;
        r_hurt_active <= 1'b1;
      end
    end
  end

  assign o_hitbox_x1      = r_hit_x1;
  assign o_hitbox_x2      = r_hit_x2;
  assign o_hitbox_y1      = r_hit_y1;
  assign o_hitbox_y2      = r_hit_y2;
  assign o_hurtbox_x1     = r_hurt_x1;
  assign o_hurtbox_x2     = r_hurt_x2;
  assign o_hurtbox_y1     = r_hurt_y1;
  assign o_hurtbox_y2     = r_hurt_y2;
  assign o_hitbox_active  = r_hit_active;
  assign o_hurtbox_active = r_hurt_active;
  assign o_act_cnt        = r_act_cnt;

endmodule
